// File: rtl/teclado_debounce.sv
// teclado_debounce
// Input conditioning for the synthesizer keyboard. Each raw key line is
// synchronized into the clk domain and debounced on a slow sample tick.
// The clean levels drive the teclado vector. Every accepted level change
// is also queued as a press/release event in a small FIFO that firmware
// drains with a pop handshake.
module teclado_debounce #(
    parameter int N_KEYS     = 13,
    parameter int TICK_DIV   = 50000,
    parameter int DB_COUNT   = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_KEYS-1:0]             keys_raw,
    output logic [N_KEYS-1:0]             teclado,
    output logic                          evt_valid,
    output logic [4:0]                    evt_data,
    input  logic                          evt_rd,
    output logic                          evt_overflow,
    input  logic                          evt_ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [7:0]    DB_LAST   = 8'(DB_COUNT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Two-flop synchronizer per key line
    // ------------------------------------------------------------------
    logic [N_KEYS-1:0] sync1_reg;
    logic [N_KEYS-1:0] sync2_reg;

    // Bring the asynchronous key lines into the clk domain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= keys_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // ------------------------------------------------------------------
    // Debounce sample tick
    // ------------------------------------------------------------------
    logic [TW-1:0] tick_cnt_reg;
    logic          tick;

    assign tick = (tick_cnt_reg == TICK_LAST);

    // Free-running divider; tick is high on the last count of each period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Per-key debounce counters
    // ------------------------------------------------------------------
    // flip[i] is high on the cycle key i's accepted level is about to toggle.
    logic [N_KEYS-1:0] flip;

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            logic [7:0] db_reg;
            logic       level_reg;
            logic       differ;

            // The synchronized line disagrees with the accepted level.
            assign differ     = sync2_reg[gi] ^ level_reg;
            assign flip[gi]   = differ && tick && (db_reg == DB_LAST);
            assign teclado[gi] = level_reg;

            // Count ticks of persistent disagreement; any agreement restarts.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    db_reg    <= '0;
                    level_reg <= 1'b0;
                end else if (!differ) begin
                    db_reg <= '0;
                end else if (tick) begin
                    if (db_reg == DB_LAST) begin
                        level_reg <= ~level_reg;
                        db_reg    <= '0;
                    end else begin
                        db_reg <= db_reg + 8'd1;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pending events and lowest-index-first arbiter
    // ------------------------------------------------------------------
    logic [N_KEYS-1:0] pend_reg;
    logic [N_KEYS-1:0] pend_next;
    logic [N_KEYS-1:0] grant_mask;
    logic              push;
    logic [3:0]        grant_idx;
    logic              grant_level;

    // Pick the lowest pending key; scanning downward leaves the lowest winner.
    always_comb begin
        push        = 1'b0;
        grant_idx   = '0;
        grant_level = 1'b0;
        grant_mask  = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (pend_reg[i]) begin
                push        = 1'b1;
                grant_idx   = 4'(i);
                grant_level = teclado[i];
                grant_mask  = '0;
                grant_mask[i] = 1'b1;
            end
        end
        // A fresh flip wins over clearing the same bit.
        pend_next = (pend_reg & ~grant_mask) | flip;
    end

    // Hold pending bits until the arbiter has offered them to the FIFO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [4:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          ovf_reg;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          drop;

    assign full  = (count_reg == FULL_CNT);
    assign pop   = evt_rd && (count_reg != '0);
    // A simultaneous pop frees a slot, so a full FIFO can still accept.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    // Storage array, written without reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= {grant_level, grant_idx};
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (drop) begin
                ovf_reg <= 1'b1;
            end else if (evt_ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign evt_valid    = (count_reg != '0);
    // Head entry is shown straight from the array; forced to zero when empty
    // so stale storage never leaks out after reset.
    assign evt_data     = evt_valid ? mem[rd_ptr_reg] : 5'd0;
    assign evt_count    = count_reg;
    assign evt_overflow = ovf_reg;

endmodule

// File: tb/tb_teclado_debounce.sv
// Bench for teclado_debounce: directed scenarios followed by random key
// activity, all compared every cycle against a behavioural reference model.
module tb_teclado_debounce;

    localparam int N   = 13;
    localparam int TD  = 4;
    localparam int DBC = 3;
    localparam int FD  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  keys_raw;
    logic [N-1:0]  teclado;
    logic          evt_valid;
    logic [4:0]    evt_data;
    logic          evt_rd;
    logic          evt_overflow;
    logic          evt_ovf_clr;
    logic [3:0]    evt_count;

    teclado_debounce #(
        .N_KEYS(N), .TICK_DIV(TD), .DB_COUNT(DBC), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset), .keys_raw(keys_raw), .teclado(teclado),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_rd(evt_rd),
        .evt_overflow(evt_overflow), .evt_ovf_clr(evt_ovf_clr),
        .evt_count(evt_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [N-1:0] s1_m, syn_m, tec_m, pend_m;
    int           run_m [N];
    logic [4:0]   fifo_q [$];
    logic         ovf_m;
    int           cyc_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of one clk edge using the inputs present before the edge.
    task automatic model_edge();
        bit         do_pop, do_push, is_tick;
        int         size0;
        logic [4:0] pdata;
        if (!reset) begin
            s1_m = '0; syn_m = '0; tec_m = '0; pend_m = '0;
            foreach (run_m[k]) run_m[k] = 0;
            fifo_q.delete(); ovf_m = 1'b0; cyc_m = 0;
            return;
        end
        size0  = fifo_q.size();
        do_pop = evt_rd && (size0 > 0);
        do_push = 1'b0;
        pdata   = '0;
        for (int k = 0; k < N; k++) begin
            if (!do_push && pend_m[k]) begin
                do_push  = 1'b1;
                pend_m[k] = 1'b0;
                pdata    = {tec_m[k], 4'(k)};
            end
        end
        if (do_pop) void'(fifo_q.pop_front());
        if (do_push && (size0 < FD || do_pop)) fifo_q.push_back(pdata);
        if (do_push && size0 >= FD && !do_pop) ovf_m = 1'b1;
        else if (evt_ovf_clr) ovf_m = 1'b0;
        is_tick = ((cyc_m % TD) == TD - 1);
        for (int k = 0; k < N; k++) begin
            if (syn_m[k] == tec_m[k]) run_m[k] = 0;
            else if (is_tick) begin
                if (run_m[k] == DBC - 1) begin
                    tec_m[k]  = ~tec_m[k];
                    run_m[k]  = 0;
                    pend_m[k] = 1'b1;
                end else begin
                    run_m[k]++;
                end
            end
        end
        syn_m = s1_m;
        s1_m  = keys_raw;
        cyc_m++;
    endtask

    task automatic check_all();
        chk("teclado", 32'(teclado), 32'(tec_m));
        chk("evt_valid", 32'(evt_valid), 32'(fifo_q.size() > 0));
        chk("evt_data", 32'(evt_data), (fifo_q.size() > 0) ? 32'(fifo_q[0]) : 32'd0);
        chk("evt_count", 32'(evt_count), 32'(fifo_q.size()));
        chk("evt_overflow", 32'(evt_overflow), 32'(ovf_m));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pop_expect(input string tag, input logic [4:0] exp);
        chk(tag, 32'(evt_data), 32'(exp));
        evt_rd = 1'b1;
        step();
        evt_rd = 1'b0;
    endtask

    // Advance until the model has a pending push for the coming edge.
    task automatic wait_push(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (pend_m != '0) ok = 1'b1;
            else step();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic drain();
        evt_rd = 1'b1; evt_ovf_clr = 1'b1;
        run(40);
        evt_rd = 1'b0; evt_ovf_clr = 1'b0;
    endtask

    initial begin
        int hold;
        reset = 1'b0; keys_raw = '1; evt_rd = 1'b0; evt_ovf_clr = 1'b0;
        s1_m = '0; syn_m = '0; tec_m = '0; pend_m = '0; ovf_m = 1'b0; cyc_m = 0;
        foreach (run_m[k]) run_m[k] = 0;
        @(negedge clk);

        // All keys pressed through reset and after release
        run(3);
        chk("reset_teclado", 32'(teclado), 32'd0);
        chk("reset_count", 32'(evt_count), 32'd0);
        reset = 1'b1;
        run(14);
        chk("allkeys_teclado", 32'(teclado), 32'h1FFF);
        run(16);
        chk("allkeys_count", 32'(evt_count), 32'd8);
        chk("allkeys_ovf", 32'(evt_overflow), 32'd1);
        for (int i = 0; i < 8; i++) pop_expect("allkeys_order", 5'(5'h10 + i));

        // Mid-operation reset discards everything
        keys_raw = '0;
        reset = 1'b0; run(2); reset = 1'b1;
        chk("midreset_count", 32'(evt_count), 32'd0);
        chk("midreset_teclado", 32'(teclado), 32'd0);
        run(4);

        // Short pulse on key 3 is rejected
        keys_raw[3] = 1'b1; run(5);
        keys_raw[3] = 1'b0; run(30);
        chk("pulse_teclado3", 32'(teclado[3]), 32'd0);
        chk("pulse_valid", 32'(evt_valid), 32'd0);

        // Bouncing key 5 settles high, then released
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) keys_raw[5] = ~keys_raw[5];
            step();
        end
        keys_raw[5] = 1'b1;
        run(30);
        chk("bounce_teclado5", 32'(teclado[5]), 32'd1);
        chk("bounce_count", 32'(evt_count), 32'd1);
        pop_expect("bounce_press", 5'h15);
        keys_raw[5] = 1'b0;
        run(30);
        pop_expect("bounce_release", 5'h05);

        // Keys 0 and 12 together: ascending index order
        keys_raw[0] = 1'b1; keys_raw[12] = 1'b1;
        run(30);
        pop_expect("pair_first", 5'h10);
        pop_expect("pair_second", 5'h1C);
        keys_raw = '0;
        drain();

        // Full FIFO, pop in the same cycle as a push: no drop
        keys_raw = 13'h00FF;
        run(30);
        chk("full_count", 32'(evt_count), 32'd8);
        keys_raw[8] = 1'b1;
        wait_push("full_push_timeout");
        evt_rd = 1'b1; step(); evt_rd = 1'b0;
        chk("fullpop_count", 32'(evt_count), 32'd8);
        chk("fullpop_ovf", 32'(evt_overflow), 32'd0);
        for (int i = 1; i <= 8; i++) pop_expect("fullpop_order", 5'(5'h10 + i));

        // Drop coincident with clear keeps the flag; clear alone clears it
        keys_raw = 13'h0100;
        run(30);
        keys_raw = '0;
        wait_push("drop_push_timeout");
        evt_ovf_clr = 1'b1; step();
        chk("drop_wins_ovf", 32'(evt_overflow), 32'd1);
        step(); evt_ovf_clr = 1'b0;
        chk("clear_ovf", 32'(evt_overflow), 32'd0);
        drain();

        // Random key activity, pops, clears and occasional resets
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                keys_raw = keys_raw ^ (13'($urandom) & 13'($urandom));
                hold = $urandom_range(1, 16);
            end
            hold--;
            evt_rd      = ($urandom_range(0, 2) == 0);
            evt_ovf_clr = ($urandom_range(0, 9) == 0);
            reset       = ($urandom_range(0, 399) != 0);
            step();
        end
        reset = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
